// File: rtl/dzcpu_useq_pkg.sv
// Shared opcode definitions for the DZCPU micro-sequencer: uop field layout,
// flow codes, the jump-to-CB op encoding and the sequencer state encodings.
package dzcpu_useq_pkg;

    localparam int UOP_W   = 13;
    localparam int FLOW_HI = 12;
    localparam int FLOW_LO = 9;
    localparam int OP_HI   = 8;
    localparam int OP_LO   = 4;
    localparam int REG_HI  = 3;
    localparam int REG_LO  = 0;

    localparam logic [3:0] FLOW_OP           = 4'd0;
    localparam logic [3:0] FLOW_INC          = 4'd1;
    localparam logic [3:0] FLOW_EOF          = 4'd2;
    localparam logic [3:0] FLOW_INC_EOF      = 4'd3;
    localparam logic [3:0] FLOW_EOF_FU       = 4'd4;
    localparam logic [3:0] FLOW_INC_EOF_FU   = 4'd5;
    localparam logic [3:0] FLOW_INC_EOF_Z    = 4'd6;
    localparam logic [3:0] FLOW_INC_EOF_NZ   = 4'd7;
    localparam logic [3:0] FLOW_UPDATE_FLAGS = 4'd8;

    // Op field value that hands control over to the CB sub-opcode table.
    localparam logic [4:0] OP_JCB = 5'h1F;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DISP   = 3'd1,
        S_EXEC   = 3'd2,
        S_CBWAIT = 3'd3,
        S_CBDISP = 3'd4
    } state_t;

    function automatic logic [3:0] uop_flow(input logic [UOP_W-1:0] uop);
        return uop[FLOW_HI:FLOW_LO];
    endfunction

    function automatic logic [4:0] uop_op(input logic [UOP_W-1:0] uop);
        return uop[OP_HI:OP_LO];
    endfunction

    function automatic logic [3:0] uop_reg(input logic [UOP_W-1:0] uop);
        return uop[REG_HI:REG_LO];
    endfunction

endpackage

// File: rtl/dzcpu_useq_if.sv
// Bus bundle between the micro-sequencer and its memory, LUTs, ROM and
// execution datapath.
interface dzcpu_useq_if;

    logic [7:0]  iMop;
    logic        iMopValid;
    logic        iStall;
    logic        iZflag;
    logic [7:0]  iFlowIdx;
    logic [7:0]  iCbFlowIdx;
    logic [12:0] iUop;

    logic [7:0]  oIR;
    logic [7:0]  oCbIR;
    logic [7:0]  oUopAddr;
    logic [4:0]  oOp;
    logic [3:0]  oReg;
    logic        oOpEn;
    logic        oPcInc;
    logic        oFlagsWe;
    logic        oEof;
    logic        oFault;
    logic [15:0] oInstrCnt;

    modport slave (
        input  iMop, iMopValid, iStall, iZflag, iFlowIdx, iCbFlowIdx, iUop,
        output oIR, oCbIR, oUopAddr, oOp, oReg, oOpEn, oPcInc, oFlagsWe,
               oEof, oFault, oInstrCnt
    );

    modport master (
        output iMop, iMopValid, iStall, iZflag, iFlowIdx, iCbFlowIdx, iUop,
        input  oIR, oCbIR, oUopAddr, oOp, oReg, oOpEn, oPcInc, oFlagsWe,
               oEof, oFault, oInstrCnt
    );

endinterface

// File: rtl/dzcpu_useq_flowdec.sv
// Combinational decode of a uop flow code plus the Z flag into PC-increment,
// instruction-exit, flag-update and operation-enable qualifiers.
module dzcpu_useq_flowdec
    import dzcpu_useq_pkg::*;
(
    input  logic [3:0] flow,
    input  logic       zflag,
    output logic       inc,
    output logic       take_exit,
    output logic       fu,
    output logic       op_en
);

    // Flow code decode; unassigned codes fall back to plain op behaviour.
    always_comb begin
        inc       = 1'b0;
        take_exit = 1'b0;
        fu        = 1'b0;
        op_en     = 1'b1;
        case (flow)
            FLOW_OP:           op_en = 1'b1;
            FLOW_INC:          inc   = 1'b1;
            FLOW_EOF:          take_exit = 1'b1;
            FLOW_INC_EOF: begin
                inc       = 1'b1;
                take_exit = 1'b1;
            end
            FLOW_EOF_FU: begin
                take_exit = 1'b1;
                fu        = 1'b1;
            end
            FLOW_INC_EOF_FU: begin
                inc       = 1'b1;
                take_exit = 1'b1;
                fu        = 1'b1;
            end
            // Conditional exits skip the operation when taken.
            FLOW_INC_EOF_Z: begin
                inc       = 1'b1;
                take_exit = zflag;
                op_en     = ~zflag;
            end
            FLOW_INC_EOF_NZ: begin
                inc       = 1'b1;
                take_exit = ~zflag;
                op_en     = zflag;
            end
            FLOW_UPDATE_FLAGS: fu = 1'b1;
            default:           op_en = 1'b1;
        endcase
    end

endmodule

// File: rtl/dzcpu_useq.sv
// DZCPU micro-sequencer: fetches opcodes, walks their microcode flows in the
// external ROM, handles CB-prefixed opcodes and guards each flow with a watchdog.
module dzcpu_useq
    import dzcpu_useq_pkg::*;
#(
    parameter int WDOG_MAX = 63
) (
    input  logic         iClock,
    input  logic         iReset,
    dzcpu_useq_if.slave  bus
);

    localparam int             CW       = $clog2(WDOG_MAX + 1);
    localparam logic [CW-1:0]  WDOG_LIM = CW'(WDOG_MAX);

    state_t         state_r;
    logic [7:0]     ir_r;
    logic [7:0]     cbir_r;
    logic [7:0]     uaddr_r;
    logic [15:0]    instr_cnt_r;
    logic [CW-1:0]  ucnt_r;
    logic           fault_r;

    logic [3:0]     flow_s;
    logic [4:0]     op_s;
    logic           dec_inc_s;
    logic           dec_exit_s;
    logic           dec_fu_s;
    logic           dec_op_en_s;
    logic           exec_s;
    logic           jcb_s;
    logic [CW-1:0]  ucnt_next_s;
    logic           wdog_s;
    logic           op_en_s;
    logic           pc_inc_s;
    logic           flags_we_s;
    logic           eof_s;

    assign flow_s = uop_flow(bus.iUop);
    assign op_s   = uop_op(bus.iUop);

    dzcpu_useq_flowdec u_flowdec (
        .flow      (flow_s),
        .zflag     (bus.iZflag),
        .inc       (dec_inc_s),
        .take_exit (dec_exit_s),
        .fu        (dec_fu_s),
        .op_en     (dec_op_en_s)
    );

    // Same-cycle execute qualifiers for the current uop.
    always_comb begin
        exec_s      = (state_r == S_EXEC) && !bus.iStall;
        jcb_s       = (op_s == OP_JCB);
        ucnt_next_s = ucnt_r + CW'(1);
        wdog_s      = exec_s && !dec_exit_s && (ucnt_next_s >= WDOG_LIM);
        op_en_s     = exec_s && dec_op_en_s && !jcb_s;
        pc_inc_s    = exec_s && dec_inc_s;
        flags_we_s  = op_en_s && dec_fu_s;
        eof_s       = exec_s && dec_exit_s;
    end

    // Sequencer state machine with its registered outputs.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_r     <= S_FETCH;
            ir_r        <= 8'h00;
            cbir_r      <= 8'h00;
            uaddr_r     <= 8'h00;
            instr_cnt_r <= 16'h0000;
            ucnt_r      <= '0;
            fault_r     <= 1'b0;
        end else begin
            fault_r <= 1'b0;
            case (state_r)
                S_FETCH: begin
                    if (bus.iMopValid && !bus.iStall) begin
                        ir_r    <= bus.iMop;
                        state_r <= S_DISP;
                    end
                end
                S_DISP: begin
                    if (!bus.iStall) begin
                        uaddr_r <= bus.iFlowIdx;
                        ucnt_r  <= '0;
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!bus.iStall) begin
                        ucnt_r <= ucnt_next_s;
                        if (dec_exit_s) begin
                            instr_cnt_r <= instr_cnt_r + 16'd1;
                            state_r     <= S_FETCH;
                        end else if (wdog_s) begin
                            fault_r <= 1'b1;
                            state_r <= S_FETCH;
                        end else if (jcb_s) begin
                            state_r <= S_CBWAIT;
                        end else begin
                            uaddr_r <= uaddr_r + 8'd1;
                        end
                    end
                end
                S_CBWAIT: begin
                    if (bus.iMopValid && !bus.iStall) begin
                        cbir_r  <= bus.iMop;
                        state_r <= S_CBDISP;
                    end
                end
                S_CBDISP: begin
                    if (!bus.iStall) begin
                        uaddr_r <= bus.iCbFlowIdx;
                        state_r <= S_EXEC;
                    end
                end
                default: state_r <= S_FETCH;
            endcase
        end
    end

    assign bus.oIR       = ir_r;
    assign bus.oCbIR     = cbir_r;
    assign bus.oUopAddr  = uaddr_r;
    assign bus.oOp       = op_s;
    assign bus.oReg      = uop_reg(bus.iUop);
    assign bus.oOpEn     = op_en_s;
    assign bus.oPcInc    = pc_inc_s;
    assign bus.oFlagsWe  = flags_we_s;
    assign bus.oEof      = eof_s;
    assign bus.oFault    = fault_r;
    assign bus.oInstrCnt = instr_cnt_r;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Directed bench for dzcpu_useq with a small microcode ROM and opcode LUTs.
module tb_dzcpu_useq;
    import dzcpu_useq_pkg::*;

    logic iClock = 1'b0;
    logic iReset = 1'b1;
    int   total  = 0;
    int   bad    = 0;

    dzcpu_useq_if bus();

    dzcpu_useq #(.WDOG_MAX(63)) dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus)
    );

    always #5 iClock = ~iClock;

    // Microcode ROM: LDSPnn at 1, CB prefix at 13, BIT 7,H at 16, JRNZ at 17;
    // everything else is a plain op so long flows run until the watchdog.
    function automatic logic [12:0] rom(input logic [7:0] a);
        logic [3:0] f;
        logic [4:0] o;
        f = FLOW_OP;
        o = 5'd1;
        case (a)
            8'd1, 8'd2: f = FLOW_INC;
            8'd4:       f = FLOW_INC_EOF;
            8'd15:      o = OP_JCB;
            8'd16:      f = FLOW_EOF_FU;
            8'd19:      f = FLOW_INC_EOF_Z;
            8'd22:      f = FLOW_EOF;
            default:    f = FLOW_OP;
        endcase
        return {f, o, a[3:0]};
    endfunction

    function automatic logic [7:0] lut(input logic [7:0] ir);
        case (ir)
            8'h31:   return 8'd1;
            8'hCB:   return 8'd13;
            8'h20:   return 8'd17;
            8'hCD:   return 8'd48;
            8'h10:   return 8'd100;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] cblut(input logic [7:0] cbir);
        case (cbir)
            8'h7C:   return 8'd16;
            default: return 8'd0;
        endcase
    endfunction

    always_comb bus.iUop       = rom(bus.oUopAddr);
    always_comb bus.iFlowIdx   = lut(bus.oIR);
    always_comb bus.iCbFlowIdx = cblut(bus.oCbIR);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_uop(input string tag, input logic [7:0] a, input logic oe,
                              input logic pi, input logic eo, input logic fw);
        chk({tag, " addr"},  16'(bus.oUopAddr), 16'(a));
        chk({tag, " opEn"},  16'(bus.oOpEn),    16'(oe));
        chk({tag, " pcInc"}, 16'(bus.oPcInc),   16'(pi));
        chk({tag, " eof"},   16'(bus.oEof),     16'(eo));
        chk({tag, " fwe"},   16'(bus.oFlagsWe), 16'(fw));
    endtask

    task automatic cyc();
        @(posedge iClock);
        #1;
    endtask

    task automatic fetch(input logic [7:0] b);
        bus.iMopValid = 1'b1;
        bus.iMop      = b;
        cyc();
        bus.iMopValid = 1'b0;
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " addr"},  16'(bus.oUopAddr), 16'h0000);
        chk({tag, " ir"},    16'(bus.oIR),      16'h0000);
        chk({tag, " cbir"},  16'(bus.oCbIR),    16'h0000);
        chk({tag, " icnt"},  bus.oInstrCnt,     16'h0000);
        chk({tag, " opEn"},  16'(bus.oOpEn),    16'h0000);
        chk({tag, " pcInc"}, 16'(bus.oPcInc),   16'h0000);
        chk({tag, " fwe"},   16'(bus.oFlagsWe), 16'h0000);
        chk({tag, " eof"},   16'(bus.oEof),     16'h0000);
        chk({tag, " fault"}, 16'(bus.oFault),   16'h0000);
    endtask

    initial begin
        bus.iMop      = 8'h00;
        bus.iMopValid = 1'b0;
        bus.iStall    = 1'b0;
        bus.iZflag    = 1'b0;
        cyc();
        check_reset("reset");
        iReset = 1'b0;

        // Stalled fetch must not latch the opcode.
        bus.iMopValid = 1'b1;
        bus.iMop      = 8'h31;
        bus.iStall    = 1'b1;
        cyc();
        chk("fetch_stall ir", 16'(bus.oIR), 16'h0000);
        bus.iStall = 1'b0;

        // LDSPnn: 1,2,3,4 with PC increments at 1,2,4 and exit at 4.
        fetch(8'h31);
        chk("ldsp ir", 16'(bus.oIR), 16'h0031);
        expect_uop("ldsp disp", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_uop("ldsp u1", 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ldsp op", 16'(bus.oOp), 16'h0001);
        chk("ldsp reg", 16'(bus.oReg), 16'h0001);
        cyc();
        expect_uop("ldsp u2", 8'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        expect_uop("ldsp u3", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_uop("ldsp u4", 8'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("ldsp icnt", bus.oInstrCnt, 16'd1);
        chk("ldsp idle eof", 16'(bus.oEof), 16'h0000);

        // Three stalled cycles at uop 2, then the flow resumes.
        fetch(8'h31);
        cyc();
        expect_uop("stall u1", 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        bus.iStall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            expect_uop("stall hold", 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        bus.iStall = 1'b0;
        #1;
        expect_uop("stall u2", 8'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        expect_uop("stall u3", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_uop("stall u4", 8'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("stall icnt", bus.oInstrCnt, 16'd2);

        // JRNZ with Z=1 leaves at uop 19 without executing it.
        bus.iZflag = 1'b1;
        fetch(8'h20);
        cyc();
        expect_uop("jrnz_z1 u17", 8'd17, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_uop("jrnz_z1 u18", 8'd18, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_uop("jrnz_z1 u19", 8'd19, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("jrnz_z1 icnt", bus.oInstrCnt, 16'd3);

        // JRNZ with Z=0 runs the whole flow 17..22.
        bus.iZflag = 1'b0;
        fetch(8'h20);
        cyc();
        for (int a = 17; a <= 22; a++) begin
            expect_uop("jrnz_z0", 8'(a), 1'b1, (a == 19), (a == 22), 1'b0);
            cyc();
        end
        chk("jrnz_z0 icnt", bus.oInstrCnt, 16'd4);

        // CB prefix: 13,14,15(jcb), sub-opcode 0x7C, then flow 16 with flag write.
        fetch(8'hCB);
        cyc();
        expect_uop("cb u13", 8'd13, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_uop("cb u14", 8'd14, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_uop("cb u15", 8'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_uop("cb wait", 8'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch(8'h7C);
        chk("cb cbir", 16'(bus.oCbIR), 16'h007C);
        expect_uop("cb disp", 8'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_uop("cb u16", 8'd16, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc();
        chk("cb icnt", bus.oInstrCnt, 16'd5);

        // Endless op flow: watchdog fires after 63 uops.
        fetch(8'h10);
        cyc();
        for (int i = 0; i < 63; i++) begin
            expect_uop("wdog run", 8'(100 + i), 1'b1, 1'b0, 1'b0, 1'b0);
            chk("wdog run fault", 16'(bus.oFault), 16'h0000);
            cyc();
        end
        chk("wdog fault", 16'(bus.oFault), 16'h0001);
        chk("wdog addr", 16'(bus.oUopAddr), 16'd162);
        chk("wdog icnt", bus.oInstrCnt, 16'd5);
        chk("wdog eof", 16'(bus.oEof), 16'h0000);

        // Back in fetch: the next opcode (CALLnn) is accepted.
        fetch(8'hCD);
        chk("wdog pulse", 16'(bus.oFault), 16'h0000);
        chk("post_wdog ir", 16'(bus.oIR), 16'h00CD);
        cyc();
        for (int a = 48; a <= 52; a++) begin
            expect_uop("call", 8'(a), 1'b1, 1'b0, 1'b0, 1'b0);
            if (a < 52) cyc();
        end

        // Reset at uop 52 abandons the flow.
        iReset = 1'b1;
        #1;
        check_reset("midreset");
        cyc();
        check_reset("midreset hold");
        iReset = 1'b0;
        fetch(8'h31);
        chk("post_reset ir", 16'(bus.oIR), 16'h0031);
        cyc();
        expect_uop("post_reset u1", 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
